// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the PC redirect scheduler.
package pc_ctrl_pkg;

  localparam int unsigned AW = 32;
  localparam logic [AW-1:0] TRAPVEC_DEF = 32'h0000_0010;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DHALT = 2'd2
  } state_e;

endpackage

// File: rtl/pc_flush_cnt.sv
// Loadable down-counter that times the pipeline-flush window.
// Counts only while enabled (pipeline not stalled); last_c flags the final flush cycle.
module pc_flush_cnt #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic CLK,
  input  logic XRESN,
  input  logic load,
  input  logic en,
  output logic last_c
);

  localparam int unsigned CW = $clog2(FLUSH_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  // Reload on entry to flush, otherwise count down and hold at zero.
  always_ff @(posedge CLK or negedge XRESN) begin
    if (!XRESN) begin
      cnt_q <= CW'(FLUSH_CYCLES);
    end else if (load) begin
      cnt_q <= CW'(FLUSH_CYCLES);
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign last_c = (cnt_q == CW'(1));

endmodule

// File: rtl/pc_ctrl.sv
// Redirect scheduler for the PC register block: arbitrates branch, interrupt,
// MRET and debug redirects onto HLT/JREQ/JVAL and times the flush window.
// Optional debug halt support is enabled by defining PC_CTRL_DEBUG_EN.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned   FLUSH_CYCLES = 2,
  parameter logic [AW-1:0] TRAPVEC      = TRAPVEC_DEF
) (
  input  logic          CLK,
  input  logic          XRESN,
  input  logic          BHLT,
  input  logic          BRQ,
  input  logic [AW-1:0] BVAL,
  input  logic          IRQ,
  input  logic          MIE,
  input  logic          MRET,
  input  logic [AW-1:0] NXPCI,
  input  logic          DHLT,
  input  logic          DJREQ,
  input  logic [AW-1:0] DJVAL,
  output logic          HLT,
  output logic          JREQ,
  output logic [AW-1:0] JVAL,
  output logic          FLUSH,
  output logic [AW-1:0] EPC,
  output logic          IACK,
  output logic          IACT,
  output logic          DHALTED
);

  state_e        state_q, state_d;
  logic          cnt_last_c;
  logic          cnt_load;
  logic          take_irq;
  logic          take_mret;
  logic          dbg_hlt;
  logic [AW-1:0] epc_q;
  logic          iact_q;
  logic          iack_q;

`ifdef PC_CTRL_DEBUG_EN
  assign dbg_hlt = DHLT;
`else
  logic unused_dbg;
  assign dbg_hlt    = 1'b0;
  assign unused_dbg = ^{DHLT, DJREQ, DJVAL};
`endif

  // Flush-window timer; frozen while the bus stalls the pipeline.
  pc_flush_cnt #(
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) u_flush_cnt (
    .CLK    (CLK),
    .XRESN  (XRESN),
    .load   (cnt_load),
    .en     (!BHLT),
    .last_c (cnt_last_c)
  );

  assign cnt_load = (state_d == ST_FLUSH) && (state_q != ST_FLUSH);

  // State register.
  always_ff @(posedge CLK or negedge XRESN) begin
    if (!XRESN) begin
      state_q <= ST_FLUSH;
    end else begin
      state_q <= state_d;
    end
  end

  // Interrupt context: return address, in-handler flag, acknowledge pulse.
  always_ff @(posedge CLK or negedge XRESN) begin
    if (!XRESN) begin
      epc_q  <= '0;
      iact_q <= 1'b0;
      iack_q <= 1'b0;
    end else begin
      iack_q <= take_irq;
      if (take_irq) begin
        epc_q  <= BRQ ? BVAL : NXPCI;
        iact_q <= 1'b1;
      end else if (take_mret) begin
        iact_q <= 1'b0;
      end
    end
  end

  // Next-state and redirect arbitration; JREQ is only raised with HLT low.
  always_comb begin
    state_d   = state_q;
    HLT       = BHLT;
    JREQ      = 1'b0;
    JVAL      = '0;
    FLUSH     = 1'b0;
    DHALTED   = 1'b0;
    take_irq  = 1'b0;
    take_mret = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (!BHLT) begin
          if (dbg_hlt) begin
            state_d = ST_DHALT;
          end else if (IRQ && MIE && !iact_q) begin
            JREQ     = 1'b1;
            JVAL     = TRAPVEC;
            take_irq = 1'b1;
            state_d  = ST_FLUSH;
          end else if (MRET) begin
            JREQ      = 1'b1;
            JVAL      = epc_q;
            take_mret = 1'b1;
            state_d   = ST_FLUSH;
          end else if (BRQ) begin
            JREQ    = 1'b1;
            JVAL    = BVAL;
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        FLUSH = 1'b1;
        if (!BHLT && cnt_last_c) begin
          state_d = ST_RUN;
        end
      end
`ifdef PC_CTRL_DEBUG_EN
      ST_DHALT: begin
        DHALTED = 1'b1;
        HLT     = 1'b1;
        if (DJREQ) begin
          HLT  = 1'b0;
          JREQ = 1'b1;
          JVAL = DJVAL;
        end else if (!DHLT) begin
          state_d = ST_FLUSH;
        end
      end
`endif
      default: begin
        state_d = ST_FLUSH;
      end
    endcase
  end

  assign EPC  = epc_q;
  assign IACT = iact_q;
  assign IACK = iack_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed, table-driven bench for pc_ctrl (debug part runs when PC_CTRL_DEBUG_EN is defined).
module tb_pc_ctrl;

  logic        CLK;
  logic        XRESN;
  logic        BHLT, BRQ, IRQ, MIE, MRET, DHLT, DJREQ;
  logic [31:0] BVAL, NXPCI, DJVAL;
  logic        HLT, JREQ, FLUSH, IACK, IACT, DHALTED;
  logic [31:0] JVAL, EPC;

  int total;
  int bad;

  pc_ctrl dut (
    .CLK     (CLK),
    .XRESN   (XRESN),
    .BHLT    (BHLT),
    .BRQ     (BRQ),
    .BVAL    (BVAL),
    .IRQ     (IRQ),
    .MIE     (MIE),
    .MRET    (MRET),
    .NXPCI   (NXPCI),
    .DHLT    (DHLT),
    .DJREQ   (DJREQ),
    .DJVAL   (DJVAL),
    .HLT     (HLT),
    .JREQ    (JREQ),
    .JVAL    (JVAL),
    .FLUSH   (FLUSH),
    .EPC     (EPC),
    .IACK    (IACK),
    .IACT    (IACT),
    .DHALTED (DHALTED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        bh, brq, irq, mie, mret;
    logic [31:0] bval, nxpci;
    logic        e_hlt, e_jreq, e_flush, e_iack, e_iact;
    logic [31:0] e_jval, e_epc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic bh, input logic brq, input logic [31:0] bval,
                              input logic irq, input logic mie, input logic mret,
                              input logic [31:0] nxpci,
                              input logic e_hlt, input logic e_jreq, input logic [31:0] e_jval,
                              input logic e_flush, input logic e_iack, input logic e_iact,
                              input logic [31:0] e_epc);
    vec_t v;
    v.bh = bh; v.brq = brq; v.bval = bval; v.irq = irq; v.mie = mie; v.mret = mret;
    v.nxpci = nxpci; v.e_hlt = e_hlt; v.e_jreq = e_jreq; v.e_jval = e_jval;
    v.e_flush = e_flush; v.e_iack = e_iack; v.e_iact = e_iact; v.e_epc = e_epc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    BHLT = 0; BRQ = 0; BVAL = '0; IRQ = 0; MIE = 0; MRET = 0; NXPCI = '0;
    DHLT = 0; DJREQ = 0; DJVAL = '0;
  endtask

  task automatic chk_ctl(input string tag, input logic hlt, input logic jreq,
                         input logic [31:0] jval, input logic flush, input logic dh);
    check({tag, ".HLT"},     32'(HLT),     32'(hlt));
    check({tag, ".JREQ"},    32'(JREQ),    32'(jreq));
    check({tag, ".JVAL"},    JVAL,         jval);
    check({tag, ".FLUSH"},   32'(FLUSH),   32'(flush));
    check({tag, ".DHALTED"}, 32'(DHALTED), 32'(dh));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle_inputs();
    XRESN = 1'b0;

    // Reset state, with and without bus wait.
    #12;
    BHLT = 1;
    #1;
    chk_ctl("rst_bh", 1, 0, 0, 1, 0);
    BHLT = 0;
    #1;
    chk_ctl("rst", 0, 0, 0, 1, 0);
    check("rst.EPC",  EPC,        32'h0);
    check("rst.IACT", 32'(IACT),  32'h0);
    check("rst.IACK", 32'(IACK),  32'h0);

    // bh brq bval irq mie mret nxpci | hlt jreq jval flush iack iact epc
    tbl.push_back(mk(0,0,0,     0,0,0,0,     0,0,0,     1,0,0,0));     // 0 flush 1/2
    tbl.push_back(mk(0,0,0,     0,0,0,0,     0,0,0,     1,0,0,0));     // 1 flush 2/2
    tbl.push_back(mk(0,0,0,     0,0,0,0,     0,0,0,     0,0,0,0));     // 2 run
    tbl.push_back(mk(0,1,'h200, 0,0,0,0,     0,1,'h200, 0,0,0,0));     // 3 branch
    tbl.push_back(mk(0,1,'h204, 0,0,0,0,     0,0,0,     1,0,0,0));     // 4 branch ignored
    tbl.push_back(mk(0,1,'h208, 0,0,0,0,     0,0,0,     1,0,0,0));     // 5
    tbl.push_back(mk(0,0,0,     0,0,0,0,     0,0,0,     0,0,0,0));     // 6 run
    tbl.push_back(mk(0,0,0,     1,1,0,'h84,  0,1,'h10,  0,0,0,0));     // 7 irq entry
    tbl.push_back(mk(0,0,0,     1,1,0,'h84,  0,0,0,     1,1,1,'h84));  // 8 iack pulse
    tbl.push_back(mk(0,0,0,     1,1,0,'h84,  0,0,0,     1,0,1,'h84));  // 9
    tbl.push_back(mk(0,0,0,     1,1,0,'h84,  0,0,0,     0,0,1,'h84));  // 10 no re-entry
    tbl.push_back(mk(0,0,0,     0,0,1,0,     0,1,'h84,  0,0,1,'h84));  // 11 mret
    tbl.push_back(mk(0,0,0,     0,0,0,0,     0,0,0,     1,0,0,'h84));  // 12
    tbl.push_back(mk(0,0,0,     0,0,0,0,     0,0,0,     1,0,0,'h84));  // 13
    tbl.push_back(mk(0,1,'h300, 1,1,0,'h90,  0,1,'h10,  0,0,0,'h84));  // 14 irq+branch
    tbl.push_back(mk(0,0,0,     0,0,0,0,     0,0,0,     1,1,1,'h300)); // 15
    tbl.push_back(mk(0,0,0,     0,0,0,0,     0,0,0,     1,0,1,'h300)); // 16
    tbl.push_back(mk(0,0,0,     0,0,1,0,     0,1,'h300, 0,0,1,'h300)); // 17 mret
    tbl.push_back(mk(0,0,0,     0,0,0,0,     0,0,0,     1,0,0,'h300)); // 18
    tbl.push_back(mk(0,0,0,     0,0,0,0,     0,0,0,     1,0,0,'h300)); // 19
    tbl.push_back(mk(1,1,'h500, 0,0,0,0,     1,0,0,     0,0,0,'h300)); // 20 stalled branch
    tbl.push_back(mk(1,1,'h500, 0,0,0,0,     1,0,0,     0,0,0,'h300)); // 21
    tbl.push_back(mk(1,1,'h500, 0,0,0,0,     1,0,0,     0,0,0,'h300)); // 22
    tbl.push_back(mk(0,1,'h500, 0,0,0,0,     0,1,'h500, 0,0,0,'h300)); // 23 released
    tbl.push_back(mk(1,0,0,     0,0,0,0,     1,0,0,     1,0,0,'h300)); // 24 stalled flush
    tbl.push_back(mk(1,0,0,     0,0,0,0,     1,0,0,     1,0,0,'h300)); // 25
    tbl.push_back(mk(0,0,0,     0,0,0,0,     0,0,0,     1,0,0,'h300)); // 26
    tbl.push_back(mk(0,0,0,     0,0,0,0,     0,0,0,     1,0,0,'h300)); // 27
    tbl.push_back(mk(0,0,0,     0,0,0,0,     0,0,0,     0,0,0,'h300)); // 28 run
    tbl.push_back(mk(0,0,0,     1,0,0,0,     0,0,0,     0,0,0,'h300)); // 29 irq masked
    tbl.push_back(mk(1,0,0,     1,1,0,'h40,  1,0,0,     0,0,0,'h300)); // 30 irq pending
    tbl.push_back(mk(0,0,0,     1,1,0,'h44,  0,1,'h10,  0,0,0,'h300)); // 31 irq taken
    tbl.push_back(mk(0,0,0,     0,0,0,0,     0,0,0,     1,1,1,'h44));  // 32

    // Release reset and walk the table one cycle per row.
    @(negedge CLK);
    XRESN = 1'b1;
    foreach (tbl[i]) begin
      string tag;
      tag  = $sformatf("v%0d", i);
      BHLT = tbl[i].bh;  BRQ = tbl[i].brq; BVAL = tbl[i].bval;
      IRQ  = tbl[i].irq; MIE = tbl[i].mie; MRET = tbl[i].mret; NXPCI = tbl[i].nxpci;
      #1;
      chk_ctl(tag, tbl[i].e_hlt, tbl[i].e_jreq, tbl[i].e_jval, tbl[i].e_flush, 1'b0);
      check({tag, ".IACK"}, 32'(IACK), 32'(tbl[i].e_iack));
      check({tag, ".IACT"}, 32'(IACT), 32'(tbl[i].e_iact));
      check({tag, ".EPC"},  EPC,       tbl[i].e_epc);
      @(negedge CLK);
    end

    // Reset in the middle of a flush with the handler active.
    idle_inputs();
    XRESN = 1'b0;
    #1;
    chk_ctl("mrst", 0, 0, 0, 1, 0);
    check("mrst.IACT", 32'(IACT), 32'h0);
    check("mrst.EPC",  EPC,       32'h0);
    @(negedge CLK);
    XRESN = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("mrst.flush%0d", c), 32'(FLUSH), (c < 2) ? 32'h1 : 32'h0);
      check($sformatf("mrst.jreq%0d", c),  32'(JREQ),  32'h0);
      @(negedge CLK);
    end

`ifdef PC_CTRL_DEBUG_EN
    // Debug halt, PC write, and resume.
    DHLT = 1;
    #1;
    chk_ctl("dh.enter", 0, 0, 0, 0, 0);
    @(negedge CLK);
    IRQ = 1; MIE = 1;
    #1;
    chk_ctl("dh.halted", 1, 0, 0, 0, 1);
    @(negedge CLK);
    IRQ = 0; MIE = 0;
    DJREQ = 1; DJVAL = 32'h400;
    #1;
    chk_ctl("dh.write", 0, 1, 32'h400, 0, 1);
    @(negedge CLK);
    DJREQ = 0; DJVAL = '0;
    #1;
    chk_ctl("dh.after", 1, 0, 0, 0, 1);
    @(negedge CLK);
    DHLT = 0;
    #1;
    chk_ctl("dh.leave", 1, 0, 0, 0, 1);
    @(negedge CLK);
    #1;
    chk_ctl("dh.fl0", 0, 0, 0, 1, 0);
    @(negedge CLK);
    #1;
    chk_ctl("dh.fl1", 0, 0, 0, 1, 0);
    @(negedge CLK);
    #1;
    chk_ctl("dh.run", 0, 0, 0, 0, 0);
    @(negedge CLK);
`else
    // Debug inputs have no effect in the default build.
    DHLT = 1; DJREQ = 1; DJVAL = 32'h400;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk_ctl($sformatf("nodbg%0d", c), 0, 0, 0, 0, 0);
      @(negedge CLK);
    end
    idle_inputs();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Redirect scheduler for the program-counter register block.
- Arbitrates redirect sources onto that block's single HLT/JREQ/JVAL control interface. Sources are execute-stage branches, interrupt entry, MRET return and debug PC writes.
- Tracks the pipeline-flush window after every redirect.
- Holds the interrupt return address (EPC) and the in-handler flag.

Parameters:
- FLUSH_CYCLES, 2, cycles FLUSH stays high after a redirect or reset; must be at least 1.
- TRAPVEC, 32'h0000_0010, interrupt entry address.
- CW, $clog2(FLUSH_CYCLES+1), flush counter width; derived, not overridable.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- XRESN  in  1  asynchronous, active-low reset.
- BHLT  in  1  bus wait; pipeline frozen.
- BRQ  in  1  branch/jump taken, from execute.
- BVAL  in  32  branch target.
- IRQ  in  1  external interrupt, level-sensitive.
- MIE  in  1  interrupt enable from CSR.
- MRET  in  1  return-from-interrupt executed.
- NXPCI  in  32  current next-PC from the PC block.
- DHLT  in  1  debug halt request.
- DJREQ  in  1  debug PC write strobe.
- DJVAL  in  32  debug PC value.
- HLT  out  1  to PC block halt.
- JREQ  out  1  to PC block jump request.
- JVAL  out  32  to PC block jump target.
- FLUSH  out  1  pipeline kill.
- EPC  out  32  saved return address.
- IACK  out  1  one-cycle interrupt-taken pulse.
- IACT  out  1  interrupt handler active.
- DHALTED  out  1  core in debug halt.

Behaviour:
Clock, reset and output timing
- One clock (CLK); reset is asynchronous and active-low (XRESN).
- Reset values: state=FLUSH, cnt=FLUSH_CYCLES, EPC=0, IACT=0, IACK=0. Combinational outputs at reset: HLT=BHLT, JREQ=0, JVAL=0, FLUSH=1, DHALTED=0.
- Reset released mid-flush or mid-halt: everything restarts from the reset values.
- HLT, JREQ and JVAL are combinational from the registered state plus the inputs (0-cycle latency), so the PC block samples them the same edge.
- Rule: JREQ=1 only when HLT=0, because the PC block gives HLT priority over JREQ.
- JVAL=0 whenever JREQ=0.

States: RUN, FLUSH, DHALT.

RUN
- If BHLT=1: HLT=1, no redirect, no state change. Requesters hold BRQ/MRET until BHLT falls. IRQ stays pending.
- Otherwise, fixed priority:
  1. DHLT: go to DHALT, JREQ=0.
  2. IRQ&MIE&!IACT: JREQ=1, JVAL=TRAPVEC. EPC<=BRQ?BVAL:NXPCI. IACT<=1, IACK=1 for one cycle, go to FLUSH.
  3. MRET: JREQ=1, JVAL=EPC, IACT<=0, go to FLUSH.
  4. BRQ: JREQ=1, JVAL=BVAL, go to FLUSH.
  5. Otherwise stay in RUN.
- Any move to FLUSH loads cnt=FLUSH_CYCLES.

FLUSH
- FLUSH=1 throughout; BRQ and MRET are ignored (they come from killed instructions).
- IRQ and DHLT are not taken here; they stay pending.
- cnt decrements only on cycles with BHLT=0.
- cnt==1 with BHLT=0: go to RUN.

DHALT
- HLT=1 and DHALTED=1.
- DJREQ=1 for one cycle: HLT=0, JREQ=1, JVAL=DJVAL; stay in DHALT.
- DHLT=0 (DJREQ has priority if both occur in the same cycle): go to FLUSH with cnt=FLUSH_CYCLES.
- IRQ is not taken while halted.

Optional Feature:
- Macro: PC_CTRL_DEBUG_EN.
- Defined: DHALT state and DHLT/DJREQ/DJVAL behave as above.
- Undefined: DHALT state removed; DHLT, DJREQ and DJVAL ports stay present but are ignored; DHALTED is tied to 0.

Decomposition:
- Shared package pc_ctrl_pkg holds:
  - the state enum (RUN/FLUSH/DHALT);
  - the default TRAPVEC constant;
  - the 32-bit address width constant.
- One natural sub-module, pc_flush_cnt: loadable down-counter with enable=!BHLT and a last-cycle flag. It contains no other logic.

Test Plan:
- Reset release, BHLT=0: FLUSH=1 for exactly 2 cycles, then RUN; JREQ=0 throughout.
- RUN, BRQ=1, BVAL=0x200: same cycle JREQ=1, JVAL=0x200; FLUSH=1 next 2 cycles. A BRQ=1 during those cycles gives JREQ=0.
- RUN, IRQ=1, MIE=1, NXPCI=0x84: JREQ=1, JVAL=0x10, IACK pulses once; EPC=0x84 and IACT=1 next cycle. IRQ held high in the handler gives no re-entry.
- IRQ and BRQ (BVAL=0x300) in the same cycle: JVAL=0x10 and EPC=0x300. Later MRET gives JREQ=1, JVAL=0x300 and IACT=0.
- BRQ=1 with BHLT=1 for 3 cycles: HLT=1, JREQ=0. When BHLT drops, JREQ=1. During FLUSH, BHLT=1 stretches FLUSH by the stall length.
- PC_CTRL_DEBUG_EN, DHLT=1: DHALTED=1, HLT=1. DJREQ with DJVAL=0x400 gives HLT=0, JREQ=1, JVAL=0x400 for one cycle. DHLT=0 then gives 2 FLUSH cycles and a return to RUN.
